// File: rtl/sub_pkg.sv
// Shared types for the bit-serial subtractor: FSM state encoding and default width.
package sub_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int DEFAULT_WIDTH = 4;

endpackage

// File: rtl/fullsubtractor_1bit.sv
// One-bit full subtractor cell, the borrow-chain counterpart of the full-adder cell.
// Purely combinational, zero latency, no flow control.
module fullsubtractor_1bit (
  input  logic ina,
  input  logic inb,
  input  logic borrow_in,
  output logic diff_out,
  output logic borrow_out
);

  logic x_xor_y;

  assign x_xor_y    = ina ^ inb;
  assign diff_out   = x_xor_y ^ borrow_in;
  assign borrow_out = (~ina & inb) | (~x_xor_y & borrow_in);

endmodule

// File: rtl/serial_subtractor_4bit.sv
// Bit-serial a - b - borrow_in, LSB first; done pulses WIDTH+1 cycles after start.
// start is honoured only while ready (IDLE); requests during RUN/DONE are dropped, not queued.
module serial_subtractor_4bit
  import sub_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             borrow_in,
  output logic             ready,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             borrow_out
);

  localparam int            CW   = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  state_t           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] a_sh_q, a_sh_d;
  logic [WIDTH-1:0] b_sh_q, b_sh_d;
  logic [WIDTH-1:0] res_sh_q, res_sh_d;
  logic             borrow_q, borrow_d;
  logic [WIDTH-1:0] diff_q, diff_d;
  logic             bout_q, bout_d;

  logic             cell_d;
  logic             cell_bout;
  logic [WIDTH-1:0] res_next;

  fullsubtractor_1bit u_cell (
    .ina       (a_sh_q[0]),
    .inb       (b_sh_q[0]),
    .borrow_in (borrow_q),
    .diff_out  (cell_d),
    .borrow_out(cell_bout)
  );

  // Result bits arrive LSB first, so each new bit enters at the MSB end.
  assign res_next = {cell_d, res_sh_q[WIDTH-1:1]};

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    a_sh_d   = a_sh_q;
    b_sh_d   = b_sh_q;
    res_sh_d = res_sh_q;
    borrow_d = borrow_q;
    diff_d   = diff_q;
    bout_d   = bout_q;

    case (state_q)
      IDLE: begin
        if (start) begin
          a_sh_d   = a;
          b_sh_d   = b;
          borrow_d = borrow_in;
          cnt_d    = '0;
          res_sh_d = '0;
          state_d  = RUN;
        end
      end
      RUN: begin
        a_sh_d   = a_sh_q >> 1;
        b_sh_d   = b_sh_q >> 1;
        res_sh_d = res_next;
        borrow_d = cell_bout;
        cnt_d    = cnt_q + CW'(1);
        // Publish on the last bit so diff/borrow_out are already valid while done is high.
        if (cnt_q == LAST) begin
          diff_d  = res_next;
          bout_d  = cell_bout;
          state_d = DONE;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      a_sh_q   <= '0;
      b_sh_q   <= '0;
      res_sh_q <= '0;
      borrow_q <= 1'b0;
      diff_q   <= '0;
      bout_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      a_sh_q   <= a_sh_d;
      b_sh_q   <= b_sh_d;
      res_sh_q <= res_sh_d;
      borrow_q <= borrow_d;
      diff_q   <= diff_d;
      bout_q   <= bout_d;
    end
  end

  assign ready      = (state_q == IDLE);
  assign busy       = (state_q == RUN);
  assign done       = (state_q == DONE);
  assign diff       = diff_q;
  assign borrow_out = bout_q;

endmodule
